// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester A/B handshake and shared single-port memory bus.
interface rom_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;
  logic [DATA_W-1:0] a_rdata;
  logic              b_valid;
  logic              b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  a_valid, a_wen, a_addr, a_wdata, b_valid, b_wen, b_addr, b_wdata, mem_rdata,
    output a_ready, a_rdata, b_ready, b_rdata, mem_wen, mem_addr, mem_wdata
  );
  modport master (
    output a_valid, a_wen, a_addr, a_wdata, b_valid, b_wen, b_addr, b_wdata, mem_rdata,
    input  a_ready, a_rdata, b_ready, b_rdata, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one single-port memory between requesters A and B.
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  rom_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            r_state;
  state_t            w_next;
  logic              r_last_b;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_grant;
  logic              w_pick_b;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  // r_last_b doubles as the current grant owner while in ISSUE/WAIT
  always_comb begin
    w_grant       = (r_state == IDLE) && (bus.a_valid || bus.b_valid);
    w_pick_b      = bus.b_valid && (!bus.a_valid || !r_last_b);
    w_next        = r_state == IDLE ? (w_grant ? ISSUE : IDLE) : r_state == ISSUE ? WAIT : IDLE;
    bus.mem_wen   = (r_state == ISSUE) && r_wen;
    bus.a_ready   = (r_state == WAIT) && !r_last_b;
    bus.b_ready   = (r_state == WAIT) && r_last_b;
    bus.a_rdata   = bus.a_ready ? bus.mem_rdata : '0;
    bus.b_rdata   = bus.b_ready ? bus.mem_rdata : '0;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_last_b <= 1'b1;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_grant) begin
      r_last_b <= w_pick_b;
      r_wen    <= w_pick_b ? bus.b_wen   : bus.a_wen;
      r_addr   <= w_pick_b ? bus.b_addr  : bus.a_addr;
      r_wdata  <= w_pick_b ? bus.b_wdata : bus.a_wdata;
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the word-address width of the shared memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width of the shared memory.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid in 1, a_wen in 1, a_addr in ADDR_W, a_wdata in DATA_W, a_ready out 1, a_rdata out DATA_W: requester A (CPU).
REQ-006 The block SHALL have ports b_valid in 1, b_wen in 1, b_addr in ADDR_W, b_wdata in DATA_W, b_ready out 1, b_rdata out DATA_W: requester B (loader/debug).
REQ-007 The block SHALL have ports mem_wen out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: the shared single-port memory, which registers read data one cycle after the address edge and returns old content on a write.

Function
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-009 In IDLE with at least one valid asserted, the block SHALL grant one requester, latch its wen/addr/wdata into mem_wen_q/mem_addr/mem_wdata registers, and go to ISSUE on the next edge.
REQ-010 In IDLE with no valid, the block SHALL stay in IDLE; mem_addr and mem_wdata SHALL hold their last values.
REQ-011 Arbitration SHALL be round-robin: with only one valid, that requester wins; with both valid, the requester not granted last wins.
REQ-012 The last-grant register SHALL update only when a grant is made.
REQ-013 In ISSUE, mem_wen SHALL equal the latched wen of the granted requester; in every other state mem_wen SHALL be 0 (exactly one write strobe cycle per write).
REQ-014 ISSUE SHALL always proceed to WAIT on the next edge.
REQ-015 In WAIT, the granted requester's ready SHALL be 1 for exactly that cycle and its rdata SHALL equal mem_rdata; FSM returns to IDLE on the next edge.
REQ-016 Ungranted requester's ready SHALL be 0 at all times outside its own WAIT cycle; x_rdata SHALL be mem_rdata gated to 0 when that port's ready is 0.
REQ-017 Latency SHALL be fixed: valid sampled in IDLE at cycle N -> ready at cycle N+2; back-to-back service of a single requester SHALL be one transfer every 3 cycles.
REQ-018 Requesters SHALL hold valid/wen/addr/wdata until ready; if valid drops after grant, the block SHALL still complete the latched access and pulse ready.
REQ-019 A requester asserting valid during another's ISSUE/WAIT SHALL wait; it is considered at the next IDLE cycle.
REQ-020 For writes, x_rdata during ready SHALL be the pre-write memory content (pass-through of mem_rdata).
REQ-021 Address and data SHALL pass unmodified; no width conversion or byte strobes.

Reset
REQ-022 While resetn=0: state=IDLE, last-grant=B (so A wins the first contention), mem_wen=0, mem_addr=0, mem_wdata=0, a_ready=b_ready=0, a_rdata=b_rdata=0.
REQ-023 Reset asserted mid-transaction SHALL immediately force mem_wen=0 and ready outputs 0; the aborted access SHALL not complete and no ready SHALL pulse after release until a fresh grant.
REQ-024 After resetn rises, the first grant SHALL occur at the first rising edge at which a valid is sampled.

Verification
REQ-025 A-only read: memory[0x10]=0xAABBCCDD, a_valid=1,a_addr=0x10 at cycle 0 -> mem_addr=0x10 cycle 1, a_ready=1 with a_rdata=0xAABBCCDD at cycle 2, b_ready=0 throughout.
REQ-026 B write then A read: b_wen=1,b_addr=0x05,b_wdata=0x12345678 -> mem_wen=1 one cycle only, b_ready pulse; then A reads 0x05 -> 0x12345678.
REQ-027 Simultaneous valid after reset: A and B both valid at cycle 0 -> A ready at cycle 2, B ready at cycle 5; both held continuously -> strict alternation A,B,A,B.
REQ-028 Reset mid-write: assert resetn=0 during ISSUE of a B write to 0x07 -> mem_wen drops asynchronously, no b_ready, state IDLE after release.
REQ-029 Valid dropped after grant: A valid for one cycle only -> a_ready still pulses at cycle 2 with correct data; no second access.
REQ-030 Idle bus: no valid for 20 cycles -> mem_wen=0, both ready=0, mem_addr unchanged.
